// File: rtl/hmem_arbiter.sv
// hmem_arbiter: shares one higher-level memory port between the D-cache (port 0)
// and the I-cache (port 1). A grant is held for the owner's whole miss sequence
// (writeback plus allocate/flush bursts) and handed over on release.
// Build option: define HMEM_ARB_ROUND_ROBIN_EN to break IDLE ties round-robin;
// without it, port 0 always wins ties.
module hmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OP_W   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [OP_W-1:0]   req0_operation,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_fulfilled,
    input  logic              req1_valid,
    input  logic [OP_W-1:0]   req1_operation,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_fulfilled,
    output logic              mem_req_valid,
    output logic [OP_W-1:0]   mem_req_operation,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_fulfilled,
    output logic [1:0]        owner
);

    // memory_operation_e encoding
    localparam logic [OP_W-1:0] OP_LOAD = '0;

    // state     | meaning
    // ST_IDLE   | no owner, memory port quiet
    // ST_GRANT0 | D-cache owns the port until it drops req0_valid
    // ST_GRANT1 | I-cache owns the port until it drops req1_valid
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   spurious_fulfilled;

    // Load data is broadcast; only the fulfilled strobe qualifies it.
    assign req0_rdata = mem_rdata;
    assign req1_rdata = mem_rdata;

`ifdef HMEM_ARB_ROUND_ROBIN_EN
    // last_q: port granted most recently (1 after reset so port 0 is favoured).
    logic last_q, last_d;

    // Round-robin pointer follows every grant, including direct handover.
    always_comb begin
        last_d = last_q;
        if (state_d == ST_GRANT0) last_d = 1'b0;
        else if (state_d == ST_GRANT1) last_d = 1'b1;
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) last_q <= 1'b1;
        else       last_q <= last_d;
    end
`endif

    // State register; reset abandons any in-flight beat.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state, Moore request mux and fulfilled routing to the owner only.
    always_comb begin
        state_d           = state_q;
        mem_req_valid     = 1'b0;
        mem_req_operation = OP_LOAD;
        mem_req_addr      = '0;
        mem_req_wdata     = '0;
        req0_fulfilled    = 1'b0;
        req1_fulfilled    = 1'b0;
        owner             = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid && req1_valid) begin
`ifdef HMEM_ARB_ROUND_ROBIN_EN
                    state_d = last_q ? ST_GRANT0 : ST_GRANT1;
`else
                    state_d = ST_GRANT0;
`endif
                end else if (req0_valid) begin
                    state_d = ST_GRANT0;
                end else if (req1_valid) begin
                    state_d = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                owner             = 2'b01;
                mem_req_valid     = req0_valid;
                mem_req_operation = req0_operation;
                mem_req_addr      = req0_addr;
                mem_req_wdata     = req0_wdata;
                req0_fulfilled    = mem_fulfilled & req0_valid;
                if (!req0_valid) state_d = req1_valid ? ST_GRANT1 : ST_IDLE;
            end
            ST_GRANT1: begin
                owner             = 2'b10;
                mem_req_valid     = req1_valid;
                mem_req_operation = req1_operation;
                mem_req_addr      = req1_addr;
                mem_req_wdata     = req1_wdata;
                req1_fulfilled    = mem_fulfilled & req1_valid;
                if (!req1_valid) state_d = req0_valid ? ST_GRANT0 : ST_IDLE;
            end
            default: begin
                state_d           = state_e'('x);
                mem_req_valid     = 1'bx;
                mem_req_operation = 'x;
                mem_req_addr      = 'x;
                mem_req_wdata     = 'x;
                req0_fulfilled    = 1'bx;
                req1_fulfilled    = 1'bx;
                owner             = 2'bxx;
            end
        endcase
    end

    // A memory beat completion that no active owner is waiting for.
    assign spurious_fulfilled = mem_fulfilled & ~(req0_fulfilled | req1_fulfilled);

    a_owner_onehot: assert property (@(posedge clk) disable iff (reset)
        owner != 2'b11);
    a_fulfilled_excl: assert property (@(posedge clk) disable iff (reset)
        !(req0_fulfilled && req1_fulfilled));
    a_req_stable: assert property (@(posedge clk) disable iff (reset)
        (mem_req_valid && !mem_fulfilled) |=>
        (!mem_req_valid || $stable({mem_req_operation, mem_req_addr, mem_req_wdata})));
    a_no_spurious: assert property (@(posedge clk) disable iff (reset)
        !spurious_fulfilled)
        else $warning("hmem_arbiter: mem_fulfilled with no active owner, beat dropped");

endmodule

// File: tb/tb_hmem_arbiter.sv
// Directed bench for hmem_arbiter: reset, single owner bursts, tie breaking,
// line lock with handover, reset mid-burst and stray beat completions.
module tb_hmem_arbiter;
    localparam logic LOAD  = 1'b0;
    localparam logic STORE = 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [0:0]  req0_operation = LOAD, req1_operation = LOAD;
    logic [31:0] req0_addr = '0, req1_addr = '0, req0_wdata = '0, req1_wdata = '0;
    logic [31:0] req0_rdata, req1_rdata;
    logic        req0_fulfilled, req1_fulfilled;
    logic        mem_req_valid;
    logic [0:0]  mem_req_operation;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_fulfilled = 1'b0;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hmem_arbiter #(.ADDR_W(32), .DATA_W(32), .OP_W(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_operation(req0_operation), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_rdata(req0_rdata), .req0_fulfilled(req0_fulfilled),
        .req1_valid(req1_valid), .req1_operation(req1_operation), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_rdata(req1_rdata), .req1_fulfilled(req1_fulfilled),
        .mem_req_valid(mem_req_valid), .mem_req_operation(mem_req_operation),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_rdata(mem_rdata), .mem_fulfilled(mem_fulfilled), .owner(owner)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = 32'h55; req0_wdata = 32'h66;
        step(); step();
        n_checks++; if (owner !== 2'b00) begin n_fail++; $display("FAIL rst_owner: got %b want 00", owner); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", mem_req_valid); end
        n_checks++; if (mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_req_addr); end
        n_checks++; if (mem_req_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", mem_req_wdata); end
        n_checks++; if (mem_req_operation !== LOAD) begin n_fail++; $display("FAIL rst_op: got %b want LOAD", mem_req_operation); end
        n_checks++; if (req0_fulfilled !== 1'b0 || req1_fulfilled !== 1'b0) begin n_fail++; $display("FAIL rst_fulfilled: got %b%b want 00", req1_fulfilled, req0_fulfilled); end
        req0_valid = 1'b0; req0_addr = '0; req0_wdata = '0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_owner();
        int beats = 0;
        req0_valid = 1'b1; req0_operation = LOAD; req0_addr = 32'h100; #1;
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL idle_latency: got %b want 0", mem_req_valid); end
        step();
        n_checks++; if (owner !== 2'b01) begin n_fail++; $display("FAIL single_owner: got %b want 01", owner); end
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin n_fail++; $display("FAIL single_fwd: got valid %b addr %h want 1 100", mem_req_valid, mem_req_addr); end
        for (int i = 0; i < 4; i++) begin
            req0_addr = 32'h100 + i * 4; mem_rdata = 32'hD000_0000 + i; mem_fulfilled = 1'b1; #1;
            if (req0_fulfilled === 1'b1) beats++;
            n_checks++; if (mem_req_addr !== 32'h100 + i * 4) begin n_fail++; $display("FAIL single_beat_addr[%0d]: got %h want %h", i, mem_req_addr, 32'h100 + i * 4); end
            n_checks++; if (req0_rdata !== 32'hD000_0000 + i || req1_rdata !== 32'hD000_0000 + i) begin n_fail++; $display("FAIL single_rdata[%0d]: got %h/%h want %h", i, req0_rdata, req1_rdata, 32'hD000_0000 + i); end
            n_checks++; if (req1_fulfilled !== 1'b0) begin n_fail++; $display("FAIL single_other_ful[%0d]: got %b want 0", i, req1_fulfilled); end
            step();
        end
        n_checks++; if (beats !== 4) begin n_fail++; $display("FAIL single_beats: got %0d want 4", beats); end
        mem_fulfilled = 1'b0; req0_valid = 1'b0; #1;
        n_checks++; if (mem_req_valid !== 1'b0 || owner !== 2'b01) begin n_fail++; $display("FAIL single_release: got valid %b owner %b want 0 01", mem_req_valid, owner); end
        step();
        n_checks++; if (owner !== 2'b00) begin n_fail++; $display("FAIL single_idle: got %b want 00", owner); end
    endtask

    task automatic test_tie();
        logic [1:0]  exp_owner;
        logic [31:0] exp_addr;
        reset = 1'b1; step(); reset = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 32'h200; req1_addr = 32'h400;
        step();
        n_checks++; if (owner !== 2'b01 || mem_req_addr !== 32'h200) begin n_fail++; $display("FAIL tie_first: got owner %b addr %h want 01 200", owner, mem_req_addr); end
        req0_valid = 1'b0; req1_valid = 1'b0; step();
        n_checks++; if (owner !== 2'b00) begin n_fail++; $display("FAIL tie_idle: got %b want 00", owner); end
        req0_valid = 1'b1; req1_valid = 1'b1; step();
`ifdef HMEM_ARB_ROUND_ROBIN_EN
        exp_owner = 2'b10; exp_addr = 32'h400;
`else
        exp_owner = 2'b01; exp_addr = 32'h200;
`endif
        n_checks++; if (owner !== exp_owner || mem_req_addr !== exp_addr) begin n_fail++; $display("FAIL tie_second: got owner %b addr %h want %b %h", owner, mem_req_addr, exp_owner, exp_addr); end
        req0_valid = 1'b0; req1_valid = 1'b0; step();
        n_checks++; if (owner !== 2'b00) begin n_fail++; $display("FAIL tie_idle2: got %b want 00", owner); end
    endtask

    task automatic test_lock_handover();
        logic [0:0] exp_op;
        req0_valid = 1'b1; req1_valid = 1'b0; step();
        for (int i = 0; i < 8; i++) begin
            exp_op = (i < 4) ? STORE : LOAD;
            req0_operation = exp_op; req0_addr = 32'h1000 + (i % 4) * 4; req0_wdata = 32'hC0DE_0000 + i;
            if (i == 1) begin req1_valid = 1'b1; req1_addr = 32'h2000; req1_operation = LOAD; req1_wdata = 32'h1111; end
            mem_fulfilled = 1'b1; mem_rdata = 32'hBEEF_0000 + i; #1;
            n_checks++; if (owner !== 2'b01) begin n_fail++; $display("FAIL lock_owner[%0d]: got %b want 01", i, owner); end
            n_checks++; if (mem_req_operation !== exp_op || mem_req_wdata !== 32'hC0DE_0000 + i) begin n_fail++; $display("FAIL lock_fwd[%0d]: got op %b wdata %h want %b %h", i, mem_req_operation, mem_req_wdata, exp_op, 32'hC0DE_0000 + i); end
            n_checks++; if (req0_fulfilled !== 1'b1 || req1_fulfilled !== 1'b0) begin n_fail++; $display("FAIL lock_route[%0d]: got ful1 %b ful0 %b want 0 1", i, req1_fulfilled, req0_fulfilled); end
            step();
        end
        mem_fulfilled = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (owner !== 2'b01) begin n_fail++; $display("FAIL lock_hold[%0d]: got %b want 01", i, owner); end
        end
        req0_valid = 1'b0; #1;
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL lock_no_bubble: got %b want 0", mem_req_valid); end
        step();
        n_checks++; if (owner !== 2'b10 || mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL handover: got owner %b valid %b want 10 1", owner, mem_req_valid); end
        n_checks++; if (mem_req_addr !== 32'h2000 || mem_req_wdata !== 32'h1111) begin n_fail++; $display("FAIL handover_fwd: got %h %h want 2000 1111", mem_req_addr, mem_req_wdata); end
        mem_fulfilled = 1'b1; #1;
        n_checks++; if (req1_fulfilled !== 1'b1 || req0_fulfilled !== 1'b0) begin n_fail++; $display("FAIL handover_route: got ful1 %b ful0 %b want 1 0", req1_fulfilled, req0_fulfilled); end
        step();
        mem_fulfilled = 1'b0; req1_valid = 1'b0; step();
        n_checks++; if (owner !== 2'b00) begin n_fail++; $display("FAIL handover_idle: got %b want 00", owner); end
    endtask

    task automatic test_reset_mid_burst();
        req0_valid = 1'b1; req0_operation = LOAD; req0_addr = 32'h3000; step();
        for (int i = 0; i < 2; i++) begin
            req0_addr = 32'h3000 + i * 4; mem_fulfilled = 1'b1; #1; step();
        end
        mem_fulfilled = 1'b0; req0_addr = 32'h3008; reset = 1'b1; step();
        n_checks++; if (mem_req_valid !== 1'b0 || owner !== 2'b00 || mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_idle: got valid %b owner %b addr %h want 0 00 0", mem_req_valid, owner, mem_req_addr); end
        reset = 1'b0; req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 32'h4000; req1_operation = STORE; req1_wdata = 32'h5A5A;
        step();
        n_checks++; if (owner !== 2'b10 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h4000 || mem_req_operation !== STORE) begin n_fail++; $display("FAIL midrst_fresh: got owner %b valid %b addr %h op %b want 10 1 4000 1", owner, mem_req_valid, mem_req_addr, mem_req_operation); end
        mem_fulfilled = 1'b1; #1;
        n_checks++; if (req1_fulfilled !== 1'b1) begin n_fail++; $display("FAIL midrst_ful: got %b want 1", req1_fulfilled); end
        step();
        mem_fulfilled = 1'b0; req1_valid = 1'b0; step();
        n_checks++; if (owner !== 2'b00) begin n_fail++; $display("FAIL midrst_end: got %b want 00", owner); end
    endtask

    task automatic test_spurious();
        mem_fulfilled = 1'b1; #1;
        n_checks++; if (req0_fulfilled !== 1'b0 || req1_fulfilled !== 1'b0) begin n_fail++; $display("FAIL spur_idle_route: got %b%b want 00", req1_fulfilled, req0_fulfilled); end
        n_checks++; if (dut.spurious_fulfilled !== 1'b1) begin n_fail++; $display("FAIL spur_idle_flag: got %b want 1", dut.spurious_fulfilled); end
        step();
        n_checks++; if (owner !== 2'b00 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL spur_idle_state: got owner %b valid %b want 00 0", owner, mem_req_valid); end
        mem_fulfilled = 1'b0; req0_valid = 1'b1; req0_addr = 32'h6000; step();
        n_checks++; if (owner !== 2'b01) begin n_fail++; $display("FAIL spur_grant: got %b want 01", owner); end
        req0_valid = 1'b0; mem_fulfilled = 1'b1; #1;
        n_checks++; if (req0_fulfilled !== 1'b0 || dut.spurious_fulfilled !== 1'b1) begin n_fail++; $display("FAIL spur_released: got ful0 %b flag %b want 0 1", req0_fulfilled, dut.spurious_fulfilled); end
        step();
        mem_fulfilled = 1'b0;
        n_checks++; if (owner !== 2'b00) begin n_fail++; $display("FAIL spur_end: got %b want 00", owner); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_owner();
        test_tie();
        test_lock_handover();
        test_reset_mid_burst();
        test_spurious();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
